// File: rtl/alu_pkg.sv
// Shared opcode, width and ALU evaluation helpers
// for the shared ALU scheduler.
package alu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_ILL = 3'b110
  } op_e;

  function automatic logic is_legal_op(
    input logic [2:0] op
  );
    return !(op[2] && op[1]);
  endfunction

  // Returns {err, result}; illegal ops give a zero result.
  function automatic logic [DATA_W:0] alu_eval(
    input logic [2:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      default: r = '0;
    endcase
    return {!is_legal_op(op), r};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: ports req/en in, one-hot gnt
// and gnt_idx out; owns the rotating priority pointer.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            found;

  always_comb begin
    int s;
    logic [ID_W-1:0] cand;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    s       = 0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      s = int'(ptr_q) + k;
      if (s >= N_REQ) s = s - N_REQ;
      cand = ID_W'(s);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      if (gnt_idx == ID_W'(N_REQ - 1))
        ptr_d = '0;
      else
        ptr_d = gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU among N_REQ valid/ready requesters;
// registered response slot with id, result, err, op_count.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [3*N_REQ-1:0]      req_opcode,
  input  logic [DATA_W*N_REQ-1:0] req_a,
  input  logic [DATA_W*N_REQ-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_result,
  output logic                    rsp_err,
  output logic [15:0]             op_count
);

  logic              slot_free;
  logic              arb_en;
  logic              any_gnt;
  logic              rsp_take;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic [2:0]        op;
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W:0]   alu_out;

  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_err_q, rsp_err_d;
  logic [15:0]       op_count_q, op_count_d;

  assign slot_free = !rsp_valid_q || rsp_ready;
  // Gate with rst_n so no ready leaks out while held in reset.
  assign arb_en    = slot_free && rst_n;
  assign rsp_take  = rsp_valid_q && rsp_ready;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign any_gnt   = |gnt;

  always_comb begin
    op   = '0;
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        op   = req_opcode[3*i +: 3];
        op_a = req_a[DATA_W*i +: DATA_W];
        op_b = req_b[DATA_W*i +: DATA_W];
      end
    end
    alu_out = alu_eval(op, op_a, op_b);
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    op_count_d   = op_count_q;
    if (rsp_take) begin
      rsp_valid_d = 1'b0;
      if (op_count_q != 16'hFFFF)
        op_count_d = op_count_q + 16'd1;
    end
    if (any_gnt) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = gnt_idx;
      rsp_result_d = alu_out[DATA_W-1:0];
      rsp_err_d    = alu_out[DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      op_count_q   <= op_count_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed-vector bench for alu_rr_scheduler
// with hand-computed expected responses.
module tb_alu_rr_scheduler;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [3*N-1:0] req_opcode;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_err;
  logic [15:0]    op_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(
    .N_REQ (N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .op_count   (op_count)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic setr(
    input int          i,
    input logic        v,
    input logic [2:0]  op,
    input logic [15:0] a,
    input logic [15:0] b
  );
    req_valid[i]        = v;
    req_opcode[3*i +: 3] = op;
    req_a[W*i +: W]     = a;
    req_b[W*i +: W]     = b;
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b1;

    // reset state, ready held low in reset
    setr(0, 1'b1, 3'b000, 16'hFFFF, 16'h0001);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    chk("rst_result", 32'(rsp_result), 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
    chk("rst_count", 32'(op_count), 32'h0);
    nxt;
    rst_n = 1'b1;

    // 1: ADD wraps to zero
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'h1);
    chk("t1_valid0", 32'(rsp_valid), 32'h0);
    nxt;
    setr(0, 1'b0, 3'b000, 16'h0, 16'h0);
    @(negedge clk);
    chk("t1_valid", 32'(rsp_valid), 32'h1);
    chk("t1_id", 32'(rsp_id), 32'h0);
    chk("t1_result", 32'(rsp_result), 32'h0);
    chk("t1_err", 32'(rsp_err), 32'h0);
    nxt;
    @(negedge clk);
    chk("t1_clear", 32'(rsp_valid), 32'h0);
    chk("t1_count", 32'(op_count), 32'h1);

    rst_n = 1'b0;
    nxt;
    rst_n = 1'b1;

    // 2: four SUB requesters, one grant per cycle
    for (int i = 0; i < N; i++)
      setr(i, 1'b1, 3'b001, 16'h0000, 16'h0001);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t2_ready%0d", k), 32'(req_ready),
          32'(1 << (k % 4)));
      if (k > 0) begin
        chk($sformatf("t2_valid%0d", k), 32'(rsp_valid), 32'h1);
        chk($sformatf("t2_id%0d", k), 32'(rsp_id),
            32'((k - 1) % 4));
        chk($sformatf("t2_res%0d", k), 32'(rsp_result),
            32'hFFFF);
      end
      nxt;
    end
    req_valid = '0;
    @(negedge clk);
    chk("t2_last_id", 32'(rsp_id), 32'h0);
    chk("t2_last_res", 32'(rsp_result), 32'hFFFF);
    nxt;
    @(negedge clk);
    chk("t2_count", 32'(op_count), 32'd5);
    chk("t2_clear", 32'(rsp_valid), 32'h0);

    // 3: XOR then back-pressure for 3 cycles
    setr(2, 1'b1, 3'b100, 16'hA5A5, 16'h0F0F);
    #1;
    chk("t3_ready", 32'(req_ready), 32'h4);
    nxt;
    setr(2, 1'b0, 3'b000, 16'h0, 16'h0);
    setr(3, 1'b1, 3'b000, 16'h0001, 16'h0002);
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t3_hold_res%0d", k), 32'(rsp_result),
          32'hAAAA);
      chk($sformatf("t3_hold_id%0d", k), 32'(rsp_id), 32'h2);
      chk($sformatf("t3_block%0d", k), 32'(req_ready), 32'h0);
      nxt;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3_refill", 32'(req_ready), 32'h8);
    nxt;
    setr(3, 1'b0, 3'b000, 16'h0, 16'h0);
    @(negedge clk);
    chk("t3_id3", 32'(rsp_id), 32'h3);
    chk("t3_res3", 32'(rsp_result), 32'h0003);
    nxt;
    @(negedge clk);
    chk("t3_count", 32'(op_count), 32'd7);

    // 4: illegal opcode
    setr(1, 1'b1, 3'b110, 16'h1234, 16'h0005);
    #1;
    chk("t4_ready", 32'(req_ready), 32'h2);
    nxt;
    setr(1, 1'b0, 3'b000, 16'h0, 16'h0);
    @(negedge clk);
    chk("t4_res", 32'(rsp_result), 32'h0);
    chk("t4_err", 32'(rsp_err), 32'h1);
    chk("t4_id", 32'(rsp_id), 32'h1);
    nxt;
    @(negedge clk);
    chk("t4_count", 32'(op_count), 32'd8);

    // 5: reset with a held response, pointer at 2
    setr(1, 1'b1, 3'b000, 16'h0001, 16'h0001);
    rsp_ready = 1'b0;
    #1;
    chk("t5_ready", 32'(req_ready), 32'h2);
    nxt;
    for (int i = 0; i < N; i++)
      setr(i, 1'b1, 3'b000, 16'h0001, 16'h0001);
    @(negedge clk);
    chk("t5_held", 32'(rsp_valid), 32'h1);
    chk("t5_held_res", 32'(rsp_result), 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(rsp_valid), 32'h0);
    chk("t5_rst_count", 32'(op_count), 32'h0);
    chk("t5_rst_ready", 32'(req_ready), 32'h0);
    setr(0, 1'b0, 3'b000, 16'h0, 16'h0);
    setr(2, 1'b0, 3'b000, 16'h0, 16'h0);
    setr(1, 1'b1, 3'b101, 16'h00FF, 16'h1111);
    setr(3, 1'b1, 3'b011, 16'h1200, 16'h0034);
    rsp_ready = 1'b1;
    nxt;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_first", 32'(req_ready), 32'h2);
    nxt;
    setr(1, 1'b0, 3'b000, 16'h0, 16'h0);
    @(negedge clk);
    chk("t5_not_id", 32'(rsp_id), 32'h1);
    chk("t5_not_res", 32'(rsp_result), 32'hFF00);
    chk("t5_next", 32'(req_ready), 32'h8);
    nxt;
    setr(3, 1'b0, 3'b000, 16'h0, 16'h0);
    @(negedge clk);
    chk("t5_or_id", 32'(rsp_id), 32'h3);
    chk("t5_or_res", 32'(rsp_result), 32'h1234);

    // 6: single requester streams until op_count saturates
    setr(0, 1'b1, 3'b010, 16'hF0F0, 16'h3C3C);
    nxt;
    @(negedge clk);
    chk("t6_and", 32'(rsp_result), 32'h3030);
    chk("t6_id", 32'(rsp_id), 32'h0);
    repeat (65600) @(posedge clk);
    @(negedge clk);
    chk("t6_sat", 32'(op_count), 32'hFFFF);
    chk("t6_stream", 32'(rsp_valid), 32'h1);
    chk("t6_self", 32'(req_ready), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
Shares one 16-bit combinational ALU between N_REQ requesters. Each requester presents an operation through a valid/ready handshake. A round-robin arbiter grants one requester per cycle, and the ALU result is captured in a single registered response slot. The response slot carries the requester ID and an illegal-opcode flag. The block sits between the instruction-issue front ends and the shared ALU datapath.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 16, operand/result width; fixed at 16 for the current ALU
ID_W, $clog2(N_REQ), requester ID width (localparam, derived)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-requester operation valid
req_ready  output  N_REQ  per-requester accept; one-hot or zero
req_opcode  input  3*N_REQ  packed opcodes; requester i at [3i+:3]
req_a  input  DATA_W*N_REQ  packed operand A
req_b  input  DATA_W*N_REQ  packed operand B
rsp_valid  output  1  response slot holds a result
rsp_ready  input  1  consumer accepts the response
rsp_id  output  ID_W  index of the requester that issued the op
rsp_result  output  DATA_W  ALU result
rsp_err  output  1  opcode was illegal (3'b110 or 3'b111)
op_count  output  16  saturating count of responses accepted by the consumer

Behaviour:
- Reset (async assert, sync deassert):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, op_count=0.
  - RR pointer=0; req_ready=0 while in reset.
  - Reset mid-operation discards the held response and any in-flight grant.
- Slot free: slot_free = !rsp_valid || rsp_ready (drain and refill in the same cycle is allowed).
- Arbitration:
  - Only when slot_free. Search req_valid starting at the RR pointer, wrapping modulo N_REQ; the first set bit wins.
  - req_ready[winner]=1 in the same cycle, combinational from req_valid and slot state. All other req_ready bits are 0.
  - No grant when the slot is blocked; all req_ready=0.
- Pointer update: on a grant to requester i, the pointer becomes (i+1) mod N_REQ. It is unchanged with no grant.
- Handshakes:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - Requesters hold valid and operands stable until accepted.
  - A requester may drop valid before acceptance without any effect on the block.
- ALU op semantics (mod 2^16, no carry/borrow out):
  - 000 ADD A+B
  - 001 SUB A-B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOT A (B ignored)
  - 110/111 illegal: result 0, err=1.
- Latency: one cycle. A grant at edge k gives rsp_valid=1 after edge k with the id/result/err of the winner.
- Response hold: while rsp_valid && !rsp_ready, rsp_id, rsp_result and rsp_err hold stable.
- Slot clear: when rsp_valid && rsp_ready and there is no new grant, rsp_valid goes to 0 next cycle. Payload outputs may keep stale values.
- Back-to-back: with rsp_ready held 1 and continuous requests, throughput is one op per cycle.
- op_count:
  - Increments on each rsp_valid && rsp_ready.
  - Saturates at 16'hFFFF.
  - Counts illegal-op responses too.
- Single requester held valid continuously is granted every cycle; the pointer wraps past it back to itself.

Decomposition:
- Shared package alu_pkg:
  - Opcode enum: OP_ADD..OP_NOT, with OP_ILL covering 3'b110/3'b111.
  - DATA_W constant.
  - Function is_legal_op(opcode).
  - Function alu_eval(opcode, a, b) returning {err, result}.
- One sub-module, rr_arbiter:
  - Inputs: req vector, enable (slot_free).
  - Outputs: one-hot grant, grant index.
  - Owns the pointer register.
- Top-level logic: operand mux by grant index, alu_eval, response register, op_count.

Test Plan:
1. Requester 0 ADD A=16'hFFFF, B=16'h0001 with rsp_ready=1 -> req_ready[0]=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=16'h0000, rsp_err=0.
2. All four requesters valid continuously with SUB A=16'h0000, B=16'h0001 and rsp_ready=1 -> grants in order 0,1,2,3,0; each response 16'hFFFF with matching rsp_id; one response per cycle.
3. Requester 2 XOR 16'hA5A5^16'h0F0F accepted, then rsp_ready=0 for 3 cycles -> rsp_result=16'hAAAA held stable; req_ready all 0 for those 3 cycles; requester 3 (valid) granted in the cycle rsp_ready returns to 1.
4. Requester 1 opcode 3'b110, A=16'h1234 -> rsp_result=16'h0000, rsp_err=1, rsp_id=1; op_count increments on acceptance.
5. rst_n pulsed low while rsp_valid=1 and the pointer is at 2 -> rsp_valid=0 immediately, op_count=0; first grant after release goes to the lowest valid index from 0.
6. Force 65,537 accepted responses -> op_count stops at 16'hFFFF.
